// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// Optional mem_err member is present only when PIPE_HAZARD_TIMEOUT_EN is defined.
interface pipe_hazard_ctrl_if;
  // Hazard sources from the pipeline
  logic [4:0] id_rs_addr;
  logic [4:0] id_rt_addr;
  logic       id_rs_use;
  logic       id_rt_use;
  logic       id_branch_taken;
  logic       ex_load;
  logic [4:0] ex_regWriteAddr;
  logic       ex_div_start;
  logic       mem_req;
  logic       mem_ready;
  // Stage-register controls back to the pipeline
  logic       stall_pc;
  logic       stall_if_id;
  logic       flush_if_id;
  logic       stall_id_ex;
  logic       bubble_id_ex;
  logic       stall_ex_mem;
  logic       bubble_ex_mem;
  logic       div_done;
  logic       busy;
`ifdef PIPE_HAZARD_TIMEOUT_EN
  logic       mem_err;
`endif

  // Pipeline side: drives hazard sources, receives controls
  modport master (
    output id_rs_addr, id_rt_addr, id_rs_use, id_rt_use, id_branch_taken,
    output ex_load, ex_regWriteAddr, ex_div_start, mem_req, mem_ready,
    input  stall_pc, stall_if_id, flush_if_id, stall_id_ex, bubble_id_ex,
    input  stall_ex_mem, bubble_ex_mem, div_done, busy
`ifdef PIPE_HAZARD_TIMEOUT_EN
    , input mem_err
`endif
  );

  // Controller side
  modport slave (
    input  id_rs_addr, id_rt_addr, id_rs_use, id_rt_use, id_branch_taken,
    input  ex_load, ex_regWriteAddr, ex_div_start, mem_req, mem_ready,
    output stall_pc, stall_if_id, flush_if_id, stall_id_ex, bubble_id_ex,
    output stall_ex_mem, bubble_ex_mem, div_done, busy
`ifdef PIPE_HAZARD_TIMEOUT_EN
    , output mem_err
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Priority: memory wait > divide occupancy > load-use > taken-branch flush.
// Optional memory-wait timeout enabled by defining PIPE_HAZARD_TIMEOUT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,  // 2..255
  parameter int unsigned TIMEOUT    = 64
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StRun, StDivBusy} state_e;

  localparam logic [7:0] DivLoad = 8'(DIV_CYCLES - 2);

  state_e     r_state;
  logic [7:0] r_div_cnt;

  logic w_mem_stall_raw;
  logic w_mem_stall;
  logic w_in_div;
  logic w_div_start;
  logic w_div_hold;
  logic w_div_finish;
  logic w_dep;
  logic w_load_use;
  logic w_hold_front;

  assign w_mem_stall_raw = bus.mem_req & ~bus.mem_ready;

`ifdef PIPE_HAZARD_TIMEOUT_EN
  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  logic [7:0] r_wait_cnt;
  logic       r_mem_err;
  logic       w_timed_out;

  assign w_timed_out = (r_wait_cnt == TimeoutVal);
  // Once the wait bound is hit the access is abandoned and the pipeline moves on
  assign w_mem_stall = w_mem_stall_raw & ~w_timed_out;
  assign bus.mem_err = r_mem_err;

  // Consecutive-wait counter (saturates at TIMEOUT) and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else if (!w_mem_stall_raw) begin
      r_wait_cnt <= 8'd0;
    end else if (!w_timed_out) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
      if (r_wait_cnt + 8'd1 == TimeoutVal) begin
        r_mem_err <= 1'b1;
      end
    end
  end
`else
  assign w_mem_stall = w_mem_stall_raw;
`endif

  // State-derived terms are masked during reset so a reset mid-divide is silent
  assign w_in_div     = (r_state == StDivBusy) & ~rst;
  assign w_div_start  = ~w_in_div & bus.ex_div_start & ~w_mem_stall;
  assign w_div_hold   = w_in_div | w_div_start;
  assign w_div_finish = w_in_div & (r_div_cnt == 8'd0) & ~w_mem_stall;

  assign w_dep = (bus.id_rs_use & (bus.id_rs_addr == bus.ex_regWriteAddr)) |
                 (bus.id_rt_use & (bus.id_rt_addr == bus.ex_regWriteAddr));
  assign w_load_use = bus.ex_load & (bus.ex_regWriteAddr != 5'd0) & w_dep &
                      ~w_mem_stall & ~w_div_hold;

  assign w_hold_front = w_mem_stall | w_div_hold | w_load_use;

  // Stage-register controls, combinational from state and current inputs
  always_comb begin
    bus.stall_pc      = w_hold_front;
    bus.stall_if_id   = w_hold_front;
    bus.flush_if_id   = bus.id_branch_taken & ~w_hold_front;
    bus.stall_id_ex   = w_mem_stall | w_div_hold;
    bus.bubble_id_ex  = w_load_use;
    bus.stall_ex_mem  = w_mem_stall;
    bus.bubble_ex_mem = w_div_hold & ~w_mem_stall;
    // Pulse comes from the registered counter reaching zero, held off by memory waits
    bus.div_done      = w_div_finish;
    bus.busy          = w_in_div;
  end

  // Divide sequencer: counter keeps running through memory waits, exit waits for them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StRun;
      r_div_cnt <= 8'd0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_div_start) begin
            r_state   <= StDivBusy;
            r_div_cnt <= DivLoad;
          end
        end
        StDivBusy: begin
          if (r_div_cnt != 8'd0) begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end else if (!w_mem_stall) begin
            r_state <= StRun;
          end
        end
        default: r_state <= StRun;
      endcase
    end
  end

endmodule
